sar_adc_sequencer: RTL and testbench

Successive-approximation ADC sequencer: the input-direction counterpart of the SID/NTSC audio/video path, reusing an `r2r_dac_buffered` instance as the reference DAC and an external comparator on a bidir pad to digitize up to four analog channels round-robin. Results feed `gpiochip` on its `adc_out_1..3` inputs. It is one clock domain; the comparator input is asynchronous and is synchronized internally.

---
 rtl/sar_pkg.sv | 26 ++
 rtl/sync2.sv | 27 ++
 rtl/sar_adc_sequencer.sv | 139 +++++++++++++
 tb/tb_sar_adc_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// sar_pkg : shared types and sizing helpers for the SAR ADC sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_TRIAL  = 2'd2,
    ST_DONE   = 2'd3
  } sar_state_t;

  localparam int CH_W = 2;

  // One counter serves both the acquisition and per-bit settle phases.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// sync2 : two-flop synchronizer for asynchronous pad inputs, resets to 0
// Rev 1.0
// ----------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sar_adc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// sar_adc_sequencer : round-robin successive-approximation conversion control
// Rev 1.0
// ----------------------------------------------------------------------------
module sar_adc_sequencer
  import sar_pkg::*;
#(
  parameter int BITS          = 12,
  parameter int NUM_CH        = 3,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic            clk_i,
  input  logic            rst_override_n,
  input  logic            enable_i,
  input  logic            cmp_i,
  output logic [BITS-1:0] dac_o,
  output logic            sample_o,
  output logic [CH_W-1:0] ch_sel_o,
  output logic [BITS-1:0] adc_out_1,
  output logic [BITS-1:0] adc_out_2,
  output logic [BITS-1:0] adc_out_3,
  output logic [BITS-1:0] result_o,
  output logic [CH_W-1:0] result_ch_o,
  output logic            valid_o
);

  localparam int CNT_W = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);
  localparam int IDX_W = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(BITS - 1);
  localparam logic [BITS-1:0]  DAC_MSB     = BITS'(1) << (BITS - 1);

  sar_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             cmp_s;
  logic [BITS-1:0]  bit_mask;
  logic [BITS-1:0]  trial_next;

  sync2 u_cmp_sync (
    .clk   (clk_i),
    .rst_n (rst_override_n),
    .d     (cmp_i),
    .q     (cmp_s)
  );

  // Resolve the current bit from the comparator and arm the next lower one;
  // at idx 0 the shifted mask is empty so nothing new is armed.
  always_comb begin
    bit_mask   = BITS'(1) << idx;
    trial_next = (cmp_s ? dac_o : (dac_o & ~bit_mask)) | (bit_mask >> 1);
  end

  always_ff @(posedge clk_i or negedge rst_override_n) begin
    if (!rst_override_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      dac_o       <= '0;
      sample_o    <= 1'b0;
      ch_sel_o    <= '0;
      adc_out_1   <= '0;
      adc_out_2   <= '0;
      adc_out_3   <= '0;
      result_o    <= '0;
      result_ch_o <= '0;
      valid_o     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          dac_o <= '0;
          cnt   <= '0;
          if (enable_i) begin
            state    <= ST_SAMPLE;
            sample_o <= 1'b1;
          end
        end

        ST_SAMPLE: begin
          if (cnt == SAMPLE_LAST) begin
            state    <= ST_TRIAL;
            cnt      <= '0;
            sample_o <= 1'b0;
            dac_o    <= DAC_MSB;
            idx      <= IDX_MSB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_TRIAL: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            dac_o <= trial_next;
            if (idx == '0) begin
              state <= ST_DONE;
            end else begin
              idx <= idx - 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          result_o    <= dac_o;
          result_ch_o <= ch_sel_o;
          valid_o     <= 1'b1;
          case (ch_sel_o)
            2'd0:    adc_out_1 <= dac_o;
            2'd1:    adc_out_2 <= dac_o;
            2'd2:    adc_out_3 <= dac_o;
            default: ;
          endcase
          ch_sel_o <= (ch_sel_o == CH_LAST) ? '0 : ch_sel_o + 1'b1;
          dac_o    <= '0;
          cnt      <= '0;
          if (enable_i) begin
            state    <= ST_SAMPLE;
            sample_o <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sar_adc_sequencer : self-checking bench for the SAR ADC sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sar_adc_sequencer;

  localparam int BITS   = 12;
  localparam int NUM_CH = 3;
  localparam int S_CYC  = 4;
  localparam int T_CYC  = 8;
  localparam int PERIOD = S_CYC + BITS * T_CYC + 1;
  localparam int HIST   = 4096;

  logic            clk     = 1'b0;
  logic            rst_n   = 1'b0;
  logic            enable  = 1'b0;
  logic            cmp;
  logic [BITS-1:0] dac, adc1, adc2, adc3, result;
  logic            sample, valid;
  logic [1:0]      ch_sel, result_ch;

  logic [BITS-1:0] vin_tab [4];
  logic            rnd_mode = 1'b0;
  logic            rnd_cmp  = 1'b0;
  bit              cmp_hist [HIST];
  int              cyc      = 0;
  int              checks   = 0;
  int              failures = 0;

  typedef struct {
    logic [BITS-1:0] vin;
    logic [BITS-1:0] exp_res;
  } vec_t;
  vec_t vecs [6];

  sar_adc_sequencer #(
    .BITS          (BITS),
    .NUM_CH        (NUM_CH),
    .SAMPLE_CYCLES (S_CYC),
    .SETTLE_CYCLES (T_CYC)
  ) dut (
    .clk_i          (clk),
    .rst_override_n (rst_n),
    .enable_i       (enable),
    .cmp_i          (cmp),
    .dac_o          (dac),
    .sample_o       (sample),
    .ch_sel_o       (ch_sel),
    .adc_out_1      (adc1),
    .adc_out_2      (adc2),
    .adc_out_3      (adc3),
    .result_o       (result),
    .result_ch_o    (result_ch),
    .valid_o        (valid)
  );

  always #5 clk = ~clk;

  // Analog input sits at the centre of its code, so "vin > DAC" is vin >= dac.
  assign cmp = rnd_mode ? rnd_cmp : (vin_tab[ch_sel] >= dac);

  // cmp_hist[k] holds the comparator level seen at rising edge number k.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    cmp_hist[(cyc + 1) % HIST] <= cmp;
  end

  initial forever begin
    @(negedge clk);
    if ($urandom_range(0, 2) == 0) begin
      #($urandom_range(1, 3));
      rnd_cmp = ~rnd_cmp;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    enable   = 1'b0;
    rnd_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_conv(output int ce);
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    ce = cyc;
  endtask

  task automatic wait_valid(input string name, output int vcyc);
    vcyc = -1;
    for (int i = 0; i < PERIOD + 10; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        vcyc = cyc;
        break;
      end
    end
    if (vcyc < 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got no valid_o within %0d cycles, expected one pulse", name, PERIOD + 10);
    end
  endtask

  // Bit b is decided at the edge ending its settle window; the two-flop
  // synchronizer presents the comparator level from two edges earlier.
  function automatic logic [BITS-1:0] rnd_expect(input int sk);
    logic [BITS-1:0] e;
    e = '0;
    for (int b = BITS - 1; b >= 0; b--)
      e[b] = cmp_hist[(sk + S_CYC + (BITS - b) * T_CYC - 2) % HIST];
    return e;
  endfunction

  initial begin
    int ce, vc, sk;
    bit ok_s, ok_v;

    vecs[0] = '{12'hA5C, 12'hA5C};
    vecs[1] = '{12'hFFF, 12'hFFF};
    vecs[2] = '{12'h000, 12'h000};
    vecs[3] = '{12'h800, 12'h800};
    vecs[4] = '{12'h001, 12'h001};
    vecs[5] = '{12'h7FF, 12'h7FF};
    for (int i = 0; i < 4; i++) vin_tab[i] = '0;

    repeat (3) @(negedge clk);
    check("reset_dac", dac, 0);
    check("reset_outputs", {sample, ch_sel, adc1, adc2, adc3, result, result_ch, valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-channel conversions of fixed inputs, including the endpoints.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      vin_tab[0] = vecs[i].vin;
      start_conv(ce);
      check($sformatf("vec%0d_sample_on", i), {sample, dac}, {1'b1, 12'h000});
      wait_valid($sformatf("vec%0d_valid", i), vc);
      check($sformatf("vec%0d_latency", i), vc - ce, PERIOD);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      check($sformatf("vec%0d_adc_out_1", i), adc1, vecs[i].exp_res);
      check($sformatf("vec%0d_result_ch", i), result_ch, 0);
      @(negedge clk);
      check($sformatf("vec%0d_valid_width", i), valid, 0);
    end

    // Round robin across three channels, wrapping back to channel 0.
    do_reset();
    vin_tab[0] = 12'h123;
    vin_tab[1] = 12'h456;
    vin_tab[2] = 12'h789;
    start_conv(ce);
    for (int k = 0; k < 4; k++) begin
      sk = ce + k * PERIOD;
      while (cyc < sk) @(negedge clk);
      check($sformatf("rr%0d_sample_ch_sel", k), {sample, ch_sel}, {1'b1, 2'(k % NUM_CH)});
      wait_valid($sformatf("rr%0d_valid", k), vc);
      check($sformatf("rr%0d_latency", k), vc - sk, PERIOD);
      check($sformatf("rr%0d_result_ch", k), result_ch, k % NUM_CH);
      check($sformatf("rr%0d_result", k), result, vin_tab[k % NUM_CH]);
    end
    check("rr_adc_outs", {adc1, adc2, adc3}, {12'h123, 12'h456, 12'h789});

    // Drop enable 30 cycles into channel 1: it still reports, then idles.
    do_reset();
    start_conv(ce);
    wait_valid("drop_ch0_valid", vc);
    while (cyc < ce + PERIOD + 30) @(negedge clk);
    enable = 1'b0;
    wait_valid("drop_ch1_valid", vc);
    check("drop_ch1_latency", vc - ce, 2 * PERIOD);
    check("drop_ch1_result", {result_ch, result}, {2'd1, 12'h456});
    ok_s = 1'b1;
    ok_v = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sample !== 1'b0) ok_s = 1'b0;
      if (valid !== 1'b0) ok_v = 1'b0;
    end
    check("drop_idle_sample_low", ok_s, 1);
    check("drop_idle_no_valid", ok_v, 1);
    start_conv(ce);
    wait_valid("resume_valid", vc);
    check("resume_latency", vc - ce, PERIOD);
    check("resume_result", {result_ch, result}, {2'd2, 12'h789});

    // Channel 0 starts back-to-back; reset it asynchronously mid-trial.
    sk = vc;
    while (cyc < sk + 50) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_dac", dac, 0);
    check("async_reset_outputs", {sample, ch_sel, adc1, adc2, adc3, result, result_ch, valid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ce = cyc;
    wait_valid("post_reset_valid", vc);
    check("post_reset_latency", vc - ce, PERIOD);
    check("post_reset_result", {result_ch, result}, {2'd0, 12'h123});

    // Randomly toggling comparator: each result is the synchronized decisions.
    do_reset();
    rnd_mode = 1'b1;
    start_conv(ce);
    for (int k = 0; k < 5; k++) begin
      wait_valid($sformatf("rnd%0d_valid", k), vc);
      check($sformatf("rnd%0d_latency", k), vc - ce, (k + 1) * PERIOD);
      check($sformatf("rnd%0d_result", k), result, rnd_expect(ce + k * PERIOD));
      check($sformatf("rnd%0d_result_ch", k), result_ch, k % NUM_CH);
      check($sformatf("rnd%0d_no_x", k),
            $isunknown({dac, sample, ch_sel, adc1, adc2, adc3, result, result_ch, valid}), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
